// File: rtl/conv_layer_sequencer.sv
// Layer control sequencer: for every image it runs load-image, load-filter,
// convolve and store through request/done handshakes, generating all addresses.
module conv_layer_sequencer #(
    parameter int DATA_SZ        = 16,
    parameter int ADDR_SZ        = 16,
    parameter int MAX_IMG        = 32,
    parameter int MAX_FLT        = 5,
    parameter int SHARED_FILTERS = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DATA_SZ-1:0] imgs_number,
    input  logic [DATA_SZ-1:0] img_size,
    input  logic [ADDR_SZ-1:0] imgs_address,
    input  logic [DATA_SZ-1:0] filters_per_image,
    input  logic [DATA_SZ-1:0] filter_size,
    input  logic [ADDR_SZ-1:0] filter_address,
    input  logic [ADDR_SZ-1:0] out_address,
    output logic               load_enable,
    output logic [ADDR_SZ-1:0] load_addr,
    output logic [DATA_SZ-1:0] load_size,
    output logic               load_is_image,
    input  logic               load_done,
    output logic               conv_enable,
    input  logic               conv_done,
    output logic               store_enable,
    output logic [ADDR_SZ-1:0] store_addr,
    output logic [DATA_SZ-1:0] store_size,
    input  logic               store_done,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [DATA_SZ-1:0] img_count,
    output logic [DATA_SZ-1:0] flt_count
);

    typedef enum logic [2:0] {
        IDLE, CHECK, LOAD_IMG, LOAD_FLT, CONV, STORE, DONE, ERR
    } state_t;

    localparam bit SHARED = (SHARED_FILTERS != 0);

    state_t state, state_nx;
    logic   enable_d, req, fire, start, cfg_bad, reuse, last_flt, last_img, req_nx;
    logic   filter_valid;

    logic [DATA_SZ-1:0] c_imgs_number, c_img_size, c_fpi, c_fsz, out_sz;
    logic [ADDR_SZ-1:0] c_faddr, img_ptr, flt_ptr, out_ptr;
    logic [DATA_SZ-1:0] img_cnt, flt_cnt;
    logic [2*DATA_SZ-1:0] img_sq, flt_sq, out_sq;

    assign start    = enable && !enable_d;
    assign out_sz   = c_img_size - c_fsz + DATA_SZ'(1);
    assign img_sq   = {{DATA_SZ{1'b0}}, c_img_size} * {{DATA_SZ{1'b0}}, c_img_size};
    assign flt_sq   = {{DATA_SZ{1'b0}}, c_fsz} * {{DATA_SZ{1'b0}}, c_fsz};
    assign out_sq   = {{DATA_SZ{1'b0}}, out_sz} * {{DATA_SZ{1'b0}}, out_sz};
    assign reuse    = SHARED && (c_fpi == DATA_SZ'(1));
    assign last_flt = (flt_cnt + DATA_SZ'(1)) == c_fpi;
    assign last_img = (img_cnt + DATA_SZ'(1)) == c_imgs_number;

    assign cfg_bad = (c_imgs_number == '0) || (c_fpi == '0) || (c_fsz == '0) ||
                     (c_fsz > c_img_size) || (c_img_size > DATA_SZ'(MAX_IMG)) ||
                     (c_fsz > DATA_SZ'(MAX_FLT));

    // Only one request is ever live, so the done input is selected by state.
    always_comb begin
        fire = 1'b0;
        case (state)
            LOAD_IMG, LOAD_FLT: fire = req && load_done;
            CONV:               fire = req && conv_done;
            STORE:              fire = req && store_done;
            default:            fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = CHECK;
            CHECK:    state_nx = cfg_bad ? ERR : LOAD_IMG;
            LOAD_IMG: if (fire) state_nx = filter_valid ? CONV : LOAD_FLT;
            LOAD_FLT: if (fire) state_nx = CONV;
            CONV:     if (fire) state_nx = STORE;
            STORE:
                if (fire) begin
                    if (last_flt)   state_nx = last_img ? DONE : LOAD_IMG;
                    else if (reuse) state_nx = CONV;
                    else            state_nx = LOAD_FLT;
                end
            DONE, ERR: if (!enable) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // A completing request drops for at least one cycle, even when the next
    // state issues another request on the same interface.
    always_comb begin
        req_nx = 1'b0;
        case (state_nx)
            LOAD_IMG, LOAD_FLT, CONV, STORE: req_nx = !fire;
            default:                         req_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_d      <= 1'b0;
            req           <= 1'b0;
            filter_valid  <= 1'b0;
            c_imgs_number <= '0;
            c_img_size    <= '0;
            c_fpi         <= '0;
            c_fsz         <= '0;
            c_faddr       <= '0;
            img_ptr       <= '0;
            flt_ptr       <= '0;
            out_ptr       <= '0;
            img_cnt       <= '0;
            flt_cnt       <= '0;
        end else begin
            enable_d <= enable;
            req      <= req_nx;
            if (state == IDLE && start) begin
                c_imgs_number <= imgs_number;
                c_img_size    <= img_size;
                c_fpi         <= filters_per_image;
                c_fsz         <= filter_size;
                c_faddr       <= filter_address;
                img_ptr       <= imgs_address;
                flt_ptr       <= filter_address;
                out_ptr       <= out_address;
                img_cnt       <= '0;
                flt_cnt       <= '0;
                filter_valid  <= 1'b0;
            end
            if (fire) begin
                case (state)
                    LOAD_IMG: img_ptr <= img_ptr + img_sq[ADDR_SZ-1:0];
                    LOAD_FLT: begin
                        flt_ptr      <= flt_ptr + flt_sq[ADDR_SZ-1:0];
                        filter_valid <= 1'b1;
                    end
                    STORE: begin
                        out_ptr <= out_ptr + out_sq[ADDR_SZ-1:0];
                        if (!reuse) filter_valid <= 1'b0;
                        if (last_flt) begin
                            flt_cnt <= '0;
                            img_cnt <= img_cnt + DATA_SZ'(1);
                            if (SHARED) flt_ptr <= c_faddr;
                        end else begin
                            flt_cnt <= flt_cnt + DATA_SZ'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_enable   = req && (state == LOAD_IMG || state == LOAD_FLT);
    assign conv_enable   = req && (state == CONV);
    assign store_enable  = req && (state == STORE);
    assign load_is_image = (state == LOAD_IMG);
    assign load_addr     = (state == LOAD_IMG) ? img_ptr :
                           (state == LOAD_FLT) ? flt_ptr : '0;
    assign load_size     = (state == LOAD_IMG) ? c_img_size :
                           (state == LOAD_FLT) ? c_fsz : '0;
    assign store_addr    = (state == STORE) ? out_ptr : '0;
    assign store_size    = (state == STORE) ? out_sz : '0;
    assign busy          = !(state == IDLE || state == DONE || state == ERR);
    assign done          = (state == DONE) || (state == ERR);
    assign error         = (state == ERR);
    assign img_count     = img_cnt;
    assign flt_count     = flt_cnt;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Runs a private-filter and a shared-filter sequencer side by side against
// a loop-nest reference model, with a scoreboard checking every request.
module tb_conv_layer_sequencer;

    typedef struct { logic img; logic [15:0] a; logic [15:0] s; } ld_t;
    typedef struct { logic [15:0] a; logic [15:0] s; } st_t;

    logic clk = 0, reset = 1, enable = 0;
    logic [15:0] imgs_number, img_size, imgs_address, filters_per_image;
    logic [15:0] filter_size, filter_address, out_address;

    logic le[2], lii[2], ce[2], se[2], bsy[2], dn[2], er[2];
    logic [15:0] la[2], lsz[2], sa[2], ssz[2], ic[2], fc[2];
    logic dnc[2][3];

    int errors = 0, checks = 0;
    int lat_max = 0;
    bit hold_load = 0, stray = 0;
    int nloads[2], nconv[2];
    logic [15:0] last_img_addr[2];
    ld_t lq0[$], lq1[$];
    st_t sq0[$], sq1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        conv_layer_sequencer #(.SHARED_FILTERS(g)) u_dut (
            .clk(clk), .reset(reset), .enable(enable),
            .imgs_number(imgs_number), .img_size(img_size), .imgs_address(imgs_address),
            .filters_per_image(filters_per_image), .filter_size(filter_size),
            .filter_address(filter_address), .out_address(out_address),
            .load_enable(le[g]), .load_addr(la[g]), .load_size(lsz[g]),
            .load_is_image(lii[g]), .load_done(dnc[g][0]),
            .conv_enable(ce[g]), .conv_done(dnc[g][1]),
            .store_enable(se[g]), .store_addr(sa[g]), .store_size(ssz[g]),
            .store_done(dnc[g][2]),
            .busy(bsy[g]), .done(dn[g]), .error(er[g]),
            .img_count(ic[g]), .flt_count(fc[g])
        );
    end

    function automatic logic req_of(int d, int c);
        return (c == 0) ? le[d] : (c == 1) ? ce[d] : se[d];
    endfunction

    // Client responders and scoreboard monitor, all on the falling edge.
    initial begin
        int cnt[2][3];
        logic lep[2], sep[2], cep[2];
        ld_t e;
        st_t s;
        for (int d = 0; d < 2; d++) begin
            lep[d] = 0; sep[d] = 0; cep[d] = 0;
            for (int c = 0; c < 3; c++) begin dnc[d][c] = 0; cnt[d][c] = 0; end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 3; c++) begin
                    if (dnc[d][c]) dnc[d][c] = 0;
                    else if (req_of(d, c)) begin
                        if (c == 0 && hold_load) ;
                        else if (cnt[d][c] == 0) dnc[d][c] = 1;
                        else cnt[d][c]--;
                    end else cnt[d][c] = $urandom_range(lat_max, 0);
                end
                if (stray && !ce[d]) dnc[d][1] = 1;

                if (le[d] && !lep[d]) begin
                    checks++;
                    nloads[d]++;
                    if (lii[d]) last_img_addr[d] = la[d];
                    if ((d == 0 ? lq0.size() : lq1.size()) == 0) begin
                        errors++;
                        $display("FAIL load_unexpected dut%0d: got img=%0b addr=%h size=%0d, none required",
                                 d, lii[d], la[d], lsz[d]);
                    end else begin
                        e = (d == 0) ? lq0.pop_front() : lq1.pop_front();
                        if (lii[d] !== e.img || la[d] !== e.a || lsz[d] !== e.s) begin
                            errors++;
                            $display("FAIL load_req dut%0d: got img=%0b addr=%h size=%0d, required img=%0b addr=%h size=%0d",
                                     d, lii[d], la[d], lsz[d], e.img, e.a, e.s);
                        end
                    end
                end
                if (se[d] && !sep[d]) begin
                    checks++;
                    if ((d == 0 ? sq0.size() : sq1.size()) == 0) begin
                        errors++;
                        $display("FAIL store_unexpected dut%0d: got addr=%h size=%0d", d, sa[d], ssz[d]);
                    end else begin
                        s = (d == 0) ? sq0.pop_front() : sq1.pop_front();
                        if (sa[d] !== s.a || ssz[d] !== s.s) begin
                            errors++;
                            $display("FAIL store_req dut%0d: got addr=%h size=%0d, required addr=%h size=%0d",
                                     d, sa[d], ssz[d], s.a, s.s);
                        end
                    end
                end
                if (ce[d] && !cep[d]) nconv[d]++;
                lep[d] = le[d]; sep[d] = se[d]; cep[d] = ce[d];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    bit exp_err;
    int exp_n, exp_f;

    // Reference model: plain loop nest over images and filters.
    task automatic arm(int n, int isz, logic [15:0] ia, int f, int fsz,
                       logic [15:0] fa, logic [15:0] oa);
        logic [15:0] ip, fp, op, o;
        imgs_number = 16'(n); img_size = 16'(isz); imgs_address = ia;
        filters_per_image = 16'(f); filter_size = 16'(fsz);
        filter_address = fa; out_address = oa;
        exp_n = n; exp_f = f;
        exp_err = (n == 0) || (f == 0) || (fsz == 0) || (fsz > isz) || (isz > 32) || (fsz > 5);
        for (int d = 0; d < 2; d++) begin
            nloads[d] = 0; nconv[d] = 0;
            if (exp_err) continue;
            ip = ia; fp = fa; op = oa;
            o = 16'(isz - fsz + 1);
            for (int i = 0; i < n; i++) begin
                if (d == 0) lq0.push_back('{1'b1, ip, 16'(isz)});
                else        lq1.push_back('{1'b1, ip, 16'(isz)});
                ip = ip + 16'(isz * isz);
                for (int j = 0; j < f; j++) begin
                    if (!(d == 1 && f == 1 && i > 0)) begin
                        if (d == 0) lq0.push_back('{1'b0, fp, 16'(fsz)});
                        else        lq1.push_back('{1'b0, fp, 16'(fsz)});
                        fp = fp + 16'(fsz * fsz);
                    end
                    if (d == 0) sq0.push_back('{op, o});
                    else        sq1.push_back('{op, o});
                    op = op + o * o;
                end
                if (d == 1) fp = fa;
            end
        end
    endtask

    task automatic finish_layer;
        int t = 0;
        while (!(dn[0] && dn[1]) && t < 5000) begin tick; t++; end
        check("layer_completes", {31'd0, t < 5000}, 1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("error_dut%0d", d), {31'd0, er[d]}, {31'd0, exp_err});
            check($sformatf("img_count_dut%0d", d), {16'd0, ic[d]}, exp_err ? 0 : exp_n);
            check($sformatf("flt_count_dut%0d", d), {16'd0, fc[d]}, 0);
            check($sformatf("conv_reqs_dut%0d", d), nconv[d], exp_err ? 0 : exp_n * exp_f);
        end
        check("queues_drained", lq0.size() + lq1.size() + sq0.size() + sq1.size(), 0);
        enable = 0;
        tick; tick;
        check("back_to_idle", {bsy[0], dn[0], bsy[1], dn[1]}, 0);
    endtask

    task automatic run_layer(int n, int isz, logic [15:0] ia, int f, int fsz,
                             logic [15:0] fa, logic [15:0] oa);
        arm(n, isz, ia, f, fsz, fa, oa);
        enable = 1;
        finish_layer();
    endtask

    initial begin
        bit stable;
        logic [15:0] a0;
        int t, isz, fsz, n, f;
        arm(0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_outputs_dut%0d", d),
                  {le[d], ce[d], se[d], bsy[d], dn[d], er[d], la[d] | sa[d] | ic[d] | fc[d]}, 0);
        reset = 0;
        tick;

        // Two images, two private filters each, single-cycle clients.
        lat_max = 0;
        run_layer(2, 4, 16'h0100, 2, 3, 16'h0200, 16'h0300);
        check("plan1_loads", nloads[0], 6);

        // Shared single filter: loaded once for all three images.
        run_layer(3, 4, 16'h0100, 1, 3, 16'h0200, 16'h0300);
        check("shared_load_count", nloads[1], 4);
        check("private_load_count", nloads[0], 6);

        // Bad configuration: error exit two cycles after the enable edge.
        arm(1, 4, 16'h0100, 1, 5, 16'h0200, 16'h0300);
        enable = 1;
        tick;
        check("bad_cfg_cycle1", {dn[0], er[0]}, 0);
        tick;
        check("bad_cfg_err", {dn[0], er[0], dn[1], er[1]}, 4'hF);
        check("bad_cfg_no_load", nloads[0] + nloads[1], 0);
        enable = 0;
        tick; tick;
        check("bad_cfg_idle", {dn[0], er[0], bsy[0]}, 0);

        // Held load request plus a stray conv_done.
        lat_max = 2;
        hold_load = 1;
        arm(1, 6, 16'h1000, 2, 3, 16'h2000, 16'h3000);
        enable = 1;
        t = 0;
        while (!(le[0] && le[1]) && t < 100) begin tick; t++; end
        check("hold_load_seen", {31'd0, t < 100}, 1);
        a0 = la[0];
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            stray = (i == 10);
            tick;
            stable &= le[0] && (la[0] == a0);
        end
        stray = 0;
        check("hold_stable", {31'd0, stable}, 1);
        check("stray_ignored", {bsy[0], le[0], ce[0], bsy[1], le[1], ce[1]}, 6'b110110);
        hold_load = 0;
        finish_layer();

        // Reset during CONV of the second image.
        arm(2, 5, 16'h0400, 2, 2, 16'h0800, 16'h0C00);
        enable = 1;
        t = 0;
        while (!(ce[0] && ic[0] == 1) && t < 2000) begin tick; t++; end
        check("reset_mid_reached_conv", {31'd0, t < 2000}, 1);
        reset = 1;
        enable = 0;
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_mid_dut%0d", d), {ce[d], bsy[d], ic[d] | fc[d]}, 0);
        tick;
        reset = 0;
        lq0.delete(); lq1.delete(); sq0.delete(); sq1.delete();
        stray = 1;
        tick;
        stray = 0;
        tick; tick;
        check("post_reset_conv_done_ignored", {bsy[0], dn[0], ce[0], bsy[1], dn[1], ce[1]}, 0);

        // Image pointer wraps modulo 2^16.
        run_layer(2, 4, 16'hFFF0, 1, 3, 16'h0200, 16'h0300);
        check("wrap_img_addr", {16'd0, last_img_addr[0]}, 0);

        // Randomized layers, some with illegal configurations.
        lat_max = 3;
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(3, 1);
            isz = $urandom_range(9, 1);
            fsz = $urandom_range((isz < 5) ? isz : 5, 1);
            f = $urandom_range(3, 1);
            case ($urandom_range(7, 0))
                0: isz = 33;
                1: f = 0;
                2: fsz = isz + 1;
                default: ;
            endcase
            run_layer(n, isz, 16'($urandom), f, fsz, 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
